// File: rtl/pio_sm_fifo.sv
// TX/RX FIFO pair for one PIO state machine, sharing 2*DEPTH words of storage
// so that either direction can be joined to twice the depth.
module pio_sm_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             join_tx,
   input  logic             join_rx,
   input  logic             txf_wr,
   input  logic [WIDTH-1:0] txf_wdata,
   input  logic             rxf_rd,
   output logic [WIDTH-1:0] rxf_rdata,
   input  logic             sm_pull,
   output logic [WIDTH-1:0] sm_pull_data,
   input  logic             sm_push,
   input  logic [WIDTH-1:0] sm_push_data,
   output logic             tx_empty,
   output logic             tx_full,
   output logic             rx_empty,
   output logic             rx_full,
   output logic [3:0]       tx_level,
   output logic [3:0]       rx_level,
   output logic             tx_over,
   output logic             rx_under,
   output logic             tx_stall,
   output logic             rx_stall
);

   localparam int SLOTS = 2 * DEPTH;
   localparam int PW    = $clog2(SLOTS);
   localparam logic [3:0] CAP_FULL = 4'(SLOTS);
   localparam logic [3:0] CAP_HALF = 4'(DEPTH);

   typedef enum logic [1:0] {
      CFG_SPLIT   = 2'd0,
      CFG_JOIN_TX = 2'd1,
      CFG_JOIN_RX = 2'd2
   } cfg_e;

   // Both-set collapses to the split layout, so only the effective mode matters.
   function automatic cfg_e cfg_of(input logic jt, input logic jr);
      if (jt && !jr) return CFG_JOIN_TX;
      if (jr && !jt) return CFG_JOIN_RX;
      return CFG_SPLIT;
   endfunction

   function automatic logic [3:0] ptr_inc(input logic [3:0] ptr, input logic [3:0] cap);
      return (ptr == cap - 4'd1) ? 4'd0 : ptr + 4'd1;
   endfunction

   logic [WIDTH-1:0] mem [SLOTS];

   logic       join_tx_q, join_rx_q;
   logic [3:0] tx_count, tx_rptr, tx_wptr;
   logic [3:0] rx_count, rx_rptr, rx_wptr;

   cfg_e       cfg_cur, cfg_reg;
   logic       cfg_change;
   logic [3:0] tx_cap, rx_cap, rx_base;
   logic       tx_pop_ok, tx_push_ok, rx_pop_ok, rx_push_ok;
   logic [3:0] tx_raddr, tx_waddr, rx_raddr, rx_waddr;

   always_comb begin
      cfg_cur    = cfg_of(join_tx, join_rx);
      cfg_reg    = cfg_of(join_tx_q, join_rx_q);
      cfg_change = (cfg_cur != cfg_reg);
      tx_cap     = CAP_HALF;
      rx_cap     = CAP_HALF;
      rx_base    = CAP_HALF;
      case (cfg_cur)
         CFG_JOIN_TX: begin
            tx_cap = CAP_FULL;
            rx_cap = 4'd0;
         end
         CFG_JOIN_RX: begin
            tx_cap  = 4'd0;
            rx_cap  = CAP_FULL;
            rx_base = 4'd0;
         end
         default: ;
      endcase
      // A full FIFO still takes a push when the same cycle's pop frees a slot.
      tx_pop_ok  = sm_pull && (tx_count != 4'd0);
      tx_push_ok = txf_wr && ((tx_count < tx_cap) || tx_pop_ok);
      rx_pop_ok  = rxf_rd && (rx_count != 4'd0);
      rx_push_ok = sm_push && ((rx_count < rx_cap) || rx_pop_ok);
      tx_raddr   = tx_rptr;
      tx_waddr   = tx_wptr;
      rx_raddr   = rx_base + rx_rptr;
      rx_waddr   = rx_base + rx_wptr;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         join_tx_q <= join_tx;
         join_rx_q <= join_rx;
         tx_count  <= 4'd0;
         tx_rptr   <= 4'd0;
         tx_wptr   <= 4'd0;
         rx_count  <= 4'd0;
         rx_rptr   <= 4'd0;
         rx_wptr   <= 4'd0;
         tx_over   <= 1'b0;
         rx_under  <= 1'b0;
         tx_stall  <= 1'b0;
         rx_stall  <= 1'b0;
      end else if (cfg_change) begin
         join_tx_q <= join_tx;
         join_rx_q <= join_rx;
         tx_count  <= 4'd0;
         tx_rptr   <= 4'd0;
         tx_wptr   <= 4'd0;
         rx_count  <= 4'd0;
         rx_rptr   <= 4'd0;
         rx_wptr   <= 4'd0;
         tx_over   <= 1'b0;
         rx_under  <= 1'b0;
         tx_stall  <= 1'b0;
         rx_stall  <= 1'b0;
      end else begin
         join_tx_q <= join_tx;
         join_rx_q <= join_rx;
         if (tx_pop_ok)  tx_rptr <= ptr_inc(tx_rptr, tx_cap);
         if (tx_push_ok) tx_wptr <= ptr_inc(tx_wptr, tx_cap);
         if (rx_pop_ok)  rx_rptr <= ptr_inc(rx_rptr, rx_cap);
         if (rx_push_ok) rx_wptr <= ptr_inc(rx_wptr, rx_cap);
         tx_count <= tx_count + {3'd0, tx_push_ok} - {3'd0, tx_pop_ok};
         rx_count <= rx_count + {3'd0, rx_push_ok} - {3'd0, rx_pop_ok};
         tx_over  <= txf_wr && !tx_push_ok;
         tx_stall <= sm_pull && !tx_pop_ok;
         rx_stall <= sm_push && !rx_push_ok;
         rx_under <= rxf_rd && !rx_pop_ok;
      end
   end

   // Storage needs no reset: counts gate every read of it.
   always_ff @(posedge clk) begin
      if (rst && !cfg_change) begin
         if (tx_push_ok) mem[tx_waddr[PW-1:0]] <= txf_wdata;
         if (rx_push_ok) mem[rx_waddr[PW-1:0]] <= sm_push_data;
      end
   end

   always_comb begin
      tx_empty     = (tx_count == 4'd0);
      rx_empty     = (rx_count == 4'd0);
      tx_full      = (tx_count == tx_cap);
      rx_full      = (rx_count == rx_cap);
      tx_level     = tx_count;
      rx_level     = rx_count;
      sm_pull_data = tx_empty ? '0 : mem[tx_raddr[PW-1:0]];
      rxf_rdata    = rx_empty ? '0 : mem[rx_raddr[PW-1:0]];
   end

endmodule

// File: tb/tb_pio_sm_fifo.sv
// Randomized and directed bench for pio_sm_fifo, checked against a queue-based
// model of the two FIFOs and the join/flush behaviour.
module tb_pio_sm_fifo;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             join_tx = 1'b0, join_rx = 1'b0;
   logic             txf_wr = 1'b0, rxf_rd = 1'b0, sm_pull = 1'b0, sm_push = 1'b0;
   logic [WIDTH-1:0] txf_wdata = '0, sm_push_data = '0;
   logic [WIDTH-1:0] rxf_rdata, sm_pull_data;
   logic             tx_empty, tx_full, rx_empty, rx_full;
   logic [3:0]       tx_level, rx_level;
   logic             tx_over, rx_under, tx_stall, rx_stall;

   int n_checks = 0;
   int n_fail   = 0;

   pio_sm_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .join_tx(join_tx), .join_rx(join_rx),
      .txf_wr(txf_wr), .txf_wdata(txf_wdata), .rxf_rd(rxf_rd), .rxf_rdata(rxf_rdata),
      .sm_pull(sm_pull), .sm_pull_data(sm_pull_data), .sm_push(sm_push),
      .sm_push_data(sm_push_data), .tx_empty(tx_empty), .tx_full(tx_full),
      .rx_empty(rx_empty), .rx_full(rx_full), .tx_level(tx_level), .rx_level(rx_level),
      .tx_over(tx_over), .rx_under(rx_under), .tx_stall(tx_stall), .rx_stall(rx_stall)
   );

   always #5 clk = ~clk;

   // Reference model: one queue per direction plus the remembered join setting.
   logic [WIDTH-1:0] tx_q[$];
   logic [WIDTH-1:0] rx_q[$];
   logic m_jt = 1'b0, m_jr = 1'b0;
   logic e_tx_over = 1'b0, e_rx_under = 1'b0, e_tx_stall = 1'b0, e_rx_stall = 1'b0;

   function automatic int mode(input logic jt, input logic jr);
      if (jt && !jr) return 1;
      if (jr && !jt) return 2;
      return 0;
   endfunction

   function automatic int cap_tx(input int m);
      return (m == 1) ? 2 * DEPTH : (m == 2) ? 0 : DEPTH;
   endfunction

   function automatic int cap_rx(input int m);
      return (m == 2) ? 2 * DEPTH : (m == 1) ? 0 : DEPTH;
   endfunction

   task automatic model_edge();
      bit tpop, tpush, rpop, rpush;
      if (!rst || mode(join_tx, join_rx) != mode(m_jt, m_jr)) begin
         tx_q.delete();
         rx_q.delete();
         {e_tx_over, e_rx_under, e_tx_stall, e_rx_stall} = 4'b0;
      end else begin
         tpop  = sm_pull && tx_q.size() > 0;
         tpush = txf_wr && (tx_q.size() < cap_tx(mode(join_tx, join_rx)) || tpop);
         rpop  = rxf_rd && rx_q.size() > 0;
         rpush = sm_push && (rx_q.size() < cap_rx(mode(join_tx, join_rx)) || rpop);
         if (tpop) void'(tx_q.pop_front());
         if (tpush) tx_q.push_back(txf_wdata);
         if (rpop) void'(rx_q.pop_front());
         if (rpush) rx_q.push_back(sm_push_data);
         e_tx_over  = txf_wr && !tpush;
         e_tx_stall = sm_pull && !tpop;
         e_rx_stall = sm_push && !rpush;
         e_rx_under = rxf_rd && !rpop;
      end
      m_jt = join_tx;
      m_jr = join_rx;
   endtask

   // Expected status word: empties, fulls, levels, event pulses.
   function automatic logic [15:0] exp_flags();
      int m = mode(join_tx, join_rx);
      return {tx_q.size() == 0, tx_q.size() == cap_tx(m),
              rx_q.size() == 0, rx_q.size() == cap_rx(m),
              4'(tx_q.size()), 4'(rx_q.size()),
              e_tx_over, e_rx_under, e_tx_stall, e_rx_stall};
   endfunction

   function automatic logic [WIDTH-1:0] exp_tx_head();
      return (tx_q.size() > 0) ? tx_q[0] : '0;
   endfunction

   function automatic logic [WIDTH-1:0] exp_rx_head();
      return (rx_q.size() > 0) ? rx_q[0] : '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      {txf_wr, rxf_rd, sm_pull, sm_push} = 4'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      tick();
      tick();
      rst = 1'b1;
      n_checks++;
      if ({tx_empty, rx_empty, tx_full, rx_full} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 1100", {tx_empty, rx_empty, tx_full, rx_full});
      end
      n_checks++;
      if ({tx_level, rx_level} !== 8'h00 || sm_pull_data !== '0 || rxf_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_levels_data got lvl %h tx %h rx %h want 0", {tx_level, rx_level},
                  sm_pull_data, rxf_rdata);
      end
      n_checks++;
      if ({tx_over, rx_under, tx_stall, rx_stall} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_events got %b want 0000", {tx_over, rx_under, tx_stall, rx_stall});
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 4; i++) begin
         txf_wr = 1'b1;
         txf_wdata = 32'(i * 32'h11);
         tick();
      end
      idle();
      n_checks++;
      if (tx_level !== 4'd4 || tx_full !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_level got lvl %0d full %b want 4 1", tx_level, tx_full);
      end
      txf_wr = 1'b1;
      txf_wdata = 32'h55;
      tick();
      idle();
      n_checks++;
      if (tx_over !== 1'b1 || tx_level !== 4'd4) begin
         n_fail++;
         $display("FAIL fill_overflow got over %b lvl %0d want 1 4", tx_over, tx_level);
      end
      tick();
      n_checks++;
      if (tx_over !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_single_cycle got %b want 0", tx_over);
      end
      for (int i = 1; i <= 4; i++) begin
         n_checks++;
         if (sm_pull_data !== 32'(i * 32'h11)) begin
            n_fail++;
            $display("FAIL drain_word_%0d got %h want %h", i, sm_pull_data, 32'(i * 32'h11));
         end
         sm_pull = 1'b1;
         tick();
      end
      idle();
      n_checks++;
      if (tx_empty !== 1'b1 || tx_level !== 4'd0) begin
         n_fail++;
         $display("FAIL drain_empty got empty %b lvl %0d want 1 0", tx_empty, tx_level);
      end
   endtask

   task automatic test_underflow();
      rxf_rd = 1'b1;
      tick();
      idle();
      n_checks++;
      if (rx_under !== 1'b1 || rxf_rdata !== '0 || rx_level !== 4'd0) begin
         n_fail++;
         $display("FAIL rx_underflow got under %b data %h lvl %0d want 1 0 0", rx_under, rxf_rdata,
                  rx_level);
      end
      sm_pull = 1'b1;
      tick();
      idle();
      n_checks++;
      if (tx_stall !== 1'b1 || tx_level !== 4'd0) begin
         n_fail++;
         $display("FAIL tx_pull_stall got stall %b lvl %0d want 1 0", tx_stall, tx_level);
      end
      // Pointers must not have moved: next word written is the next word read.
      txf_wr = 1'b1;
      txf_wdata = 32'hC0DE;
      tick();
      idle();
      n_checks++;
      if (sm_pull_data !== 32'hC0DE) begin
         n_fail++;
         $display("FAIL stall_no_ptr_move got %h want 0000c0de", sm_pull_data);
      end
      sm_pull = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_simul_full();
      for (int i = 0; i < 4; i++) begin
         txf_wr = 1'b1;
         txf_wdata = 32'(i + 1);
         tick();
      end
      txf_wdata = 32'hAA;
      sm_pull = 1'b1;
      tick();
      idle();
      n_checks++;
      if (tx_over !== 1'b0 || tx_level !== 4'd4 || tx_full !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_full got over %b lvl %0d want 0 4", tx_over, tx_level);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (sm_pull_data !== ((i == 3) ? 32'hAA : 32'(i + 2))) begin
            n_fail++;
            $display("FAIL simul_full_order_%0d got %h want %h", i, sm_pull_data,
                     (i == 3) ? 32'hAA : 32'(i + 2));
         end
         sm_pull = 1'b1;
         tick();
      end
      idle();
   endtask

   task automatic test_empty_push_pop();
      txf_wr = 1'b1;
      txf_wdata = 32'h5;
      sm_pull = 1'b1;
      tick();
      idle();
      n_checks++;
      if (tx_stall !== 1'b1 || tx_level !== 4'd1 || sm_pull_data !== 32'h5) begin
         n_fail++;
         $display("FAIL empty_push_pop got stall %b lvl %0d head %h want 1 1 5", tx_stall, tx_level,
                  sm_pull_data);
      end
      sm_pull = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_join();
      for (int i = 0; i < 2; i++) begin
         txf_wr = 1'b1;
         txf_wdata = 32'(100 + i);
         tick();
      end
      idle();
      join_tx = 1'b1;
      txf_wr = 1'b1;
      tick();
      idle();
      n_checks++;
      if (tx_level !== 4'd0 || rx_full !== 1'b1 || rx_empty !== 1'b1 || tx_over !== 1'b0) begin
         n_fail++;
         $display("FAIL join_flush got txlvl %0d rxfull %b rxempty %b over %b want 0 1 1 0",
                  tx_level, rx_full, rx_empty, tx_over);
      end
      for (int i = 0; i < 8; i++) begin
         txf_wr = 1'b1;
         txf_wdata = 32'(200 + i);
         tick();
      end
      idle();
      n_checks++;
      if (tx_level !== 4'd8 || tx_full !== 1'b1) begin
         n_fail++;
         $display("FAIL join_depth got lvl %0d full %b want 8 1", tx_level, tx_full);
      end
      txf_wr = 1'b1;
      tick();
      idle();
      n_checks++;
      if (tx_over !== 1'b1 || tx_level !== 4'd8) begin
         n_fail++;
         $display("FAIL join_overflow got over %b lvl %0d want 1 8", tx_over, tx_level);
      end
      sm_push = 1'b1;
      tick();
      idle();
      n_checks++;
      if (rx_stall !== 1'b1 || rx_level !== 4'd0) begin
         n_fail++;
         $display("FAIL join_rx_stall got stall %b lvl %0d want 1 0", rx_stall, rx_level);
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (sm_pull_data !== 32'(200 + i)) begin
            n_fail++;
            $display("FAIL join_order_%0d got %h want %h", i, sm_pull_data, 32'(200 + i));
         end
         sm_pull = 1'b1;
         tick();
      end
      idle();
      join_tx = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         sm_push = 1'b1;
         sm_push_data = 32'(300 + i);
         tick();
      end
      n_checks++;
      if (rx_level !== 4'd3 || rxf_rdata !== 32'd300) begin
         n_fail++;
         $display("FAIL rx_prefill got lvl %0d head %h want 3 12c", rx_level, rxf_rdata);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      idle();
      n_checks++;
      if (rx_level !== 4'd0 || rx_empty !== 1'b1 || rx_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid got lvl %0d empty %b stall %b want 0 1 0", rx_level, rx_empty,
                  rx_stall);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 49) == 0) join_tx = ~join_tx;
         if ($urandom_range(0, 49) == 0) join_rx = ~join_rx;
         rst          = ($urandom_range(0, 199) != 0);
         txf_wr       = ($urandom_range(0, 99) < 55);
         sm_pull      = ($urandom_range(0, 99) < 45);
         sm_push      = ($urandom_range(0, 99) < 55);
         rxf_rd       = ($urandom_range(0, 99) < 45);
         txf_wdata    = $urandom;
         sm_push_data = $urandom;
         tick();
         n_checks++;
         if ({tx_empty, tx_full, rx_empty, rx_full, tx_level, rx_level,
              tx_over, rx_under, tx_stall, rx_stall} !== exp_flags()) begin
            n_fail++;
            $display("FAIL random_flags cyc %0d got %h want %h", c,
                     {tx_empty, tx_full, rx_empty, rx_full, tx_level, rx_level,
                      tx_over, rx_under, tx_stall, rx_stall}, exp_flags());
         end
         n_checks++;
         if (sm_pull_data !== exp_tx_head() || rxf_rdata !== exp_rx_head()) begin
            n_fail++;
            $display("FAIL random_heads cyc %0d got tx %h rx %h want tx %h rx %h", c,
                     sm_pull_data, rxf_rdata, exp_tx_head(), exp_rx_head());
         end
      end
      rst = 1'b1;
      idle();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_underflow();
      test_simul_full();
      test_empty_push_pop();
      test_join();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
